iter_div_unit: RTL and testbench
================================

Name: iter_div_unit

Overview:
Multi-cycle integer divider in the EX stage, beside the ALU. It consumes the selected A/B operands (dividend = ALU_A, divisor = ALU_B) for DIV.W/MOD.W/DIV.WU/MOD.WU. It runs a restoring radix-2 iteration, one quotient bit per cycle. It stalls the front of the pipeline until the result is ready for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
cpu_clk  input  1  pipeline clock, rising edge.
cpu_rstn  input  1  asynchronous active-low reset.
div_start  input  1  EX holds a divide op with valid operands this cycle.
div_op  input  2  0=DIV_W, 1=MOD_W, 2=DIV_WU, 3=MOD_WU.
ALU_A  input  32  dividend, from the A-operand select.
ALU_B  input  32  divisor, from the B-operand select.
flush  input  1  kill the in-flight op (branch mispredict/exception).
div_stall  output  1  freeze IF/ID/EX.
div_done  output  1  one-cycle pulse when div_result is valid.
div_result  output  32  quotient or remainder per div_op.

Behaviour:
- Reset (cpu_rstn=0, asynchronous): state=IDLE; counter, remainder, quotient and divisor registers = 0; div_done=0; div_result=0; div_stall=0.
- States: IDLE, CALC, FIN.
- IDLE:
  - On div_start && !flush: latch op, the sign flags and |ALU_A|, |ALU_B|. Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000. Unsigned ops take the operands raw. Clear remainder and set counter=0.
  - If the divisor is 0, go to FIN. Otherwise go to CALC.
- CALC, per cycle:
  - rem' = {rem[30:0], dvd[31]}, dvd shifted left.
  - If rem' >= dsr: rem = rem' - dsr and shift in quotient bit 1. Otherwise shift in 0.
  - counter++. After 32 iterations (counter==31 at the edge), go to FIN.
- FIN:
  - Apply signs: quotient is negated iff the operation is signed and the operand signs differ. Remainder takes the dividend's sign.
  - div_result is registered. div_done=1 for exactly this one cycle. Next state is IDLE.
- Latency: div_start sampled at edge N → div_done high during cycle N+33 (32 CALC cycles plus FIN). For a zero divisor, div_done is high during cycle N+1.
- div_stall is combinational: (IDLE && div_start && !flush) || CALC. It is low in FIN so that EX/MEM captures the result on the div_done cycle.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend (unmodified, sign kept).
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of the magnitude path and needs no special case.
- div_start while in CALC/FIN is ignored; operands are latched only in IDLE.
- flush in any state: next state is IDLE, no div_done, div_result unchanged. Flush wins over a simultaneous div_start.
- Mid-operation reset: immediate return to the reset values.
- div_result holds its last value until the next FIN.

Optional Feature:
Macro MINILA_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the divisor is nonzero and |dividend| < |divisor| (unsigned compare for WU ops), go directly to FIN with quotient=0 and remainder=dividend. div_done then arrives at N+1.
- Undefined: every nonzero-divisor op takes the full 33 cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- defines_pipeline.vh gains `DIV_W, `MOD_W, `DIV_WU, `MOD_WU (2-bit) and the state encodings `DIV_IDLE/`DIV_CALC/`DIV_FIN.
- One natural combinational sub-module: div_step. It takes {rem, dvd, dsr} and returns {rem_next, dvd_next, q_bit}. It is instantiated once inside iter_div_unit.

Test Plan:
- DIV_WU with A=100, B=7, start at cycle 0 → div_stall high for cycles 0–32; div_done at cycle 33; result=14. Repeat as MOD_WU → result=2.
- DIV_W with A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD (-3). MOD_W with the same operands → 0xFFFFFFFF (-1).
- DIV_W with A=0x80000000, B=0xFFFFFFFF → 0x80000000. MOD_W with the same operands → 0.
- DIV_W with A=123, B=0 → div_done one cycle after start; result 0xFFFFFFFF. MOD_W with A=123, B=0 → 123.
- Start DIV_WU with A=1000, B=3; assert flush at cycle 10 → no div_done, div_stall low from cycle 11, result unchanged. A new start at cycle 12 with A=9, B=3 → result=3 at cycle 45.
- Pulse cpu_rstn low at cycle 5 of a divide → outputs 0 immediately, state IDLE. With MINILA_DIV_EARLY_OUT_EN, DIV_WU with A=3, B=10 → done at N+1, result=0.

Source files
------------

// File: rtl/iter_div_unit_pkg.sv
// Shared types and result helper for the iterative divider.
// The optional early-out path is enabled by defining MINILA_DIV_EARLY_OUT_EN.
package iter_div_unit_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_W  = 2'd0,
        MOD_W  = 2'd1,
        DIV_WU = 2'd2,
        MOD_WU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_t;

    // Picks quotient or remainder and restores the sign from the magnitude result.
    function automatic logic [DIV_XLEN-1:0] div_pick(
        input logic                want_rem,
        input logic [DIV_XLEN-1:0] quo,
        input logic [DIV_XLEN-1:0] rem,
        input logic                neg_quo,
        input logic                neg_rem
    );
        logic [DIV_XLEN-1:0] value;
        if (want_rem) begin
            value = neg_rem ? -rem : rem;
        end else begin
            value = neg_quo ? -quo : quo;
        end
        return value;
    endfunction

endpackage

// File: rtl/iter_div_unit_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] dvd,
    input  logic [W-1:0] dsr,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] dvd_next,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // One extra bit keeps the trial subtraction exact when the divisor exceeds 2^(W-1).
    always_comb begin
        shifted  = {rem, dvd[W-1]};
        diff     = shifted - {1'b0, dsr};
        q_bit    = ~diff[W];
        rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
        dvd_next = {dvd[W-2:0], 1'b0};
    end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU beside the EX-stage ALU.
// Define MINILA_DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            cpu_clk,
    input  logic            cpu_rstn,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] ALU_A,
    input  logic [XLEN-1:0] ALU_B,
    input  logic            flush,
    output logic            div_stall,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvd;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  dsr;
    logic             want_rem;
    logic             neg_quo;
    logic             neg_rem;

    logic             start_ok;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic             dsr_zero;
    logic             early;
    logic             skip_calc;
    logic             last_iter;
    logic [XLEN-1:0]  rem_next;
    logic [XLEN-1:0]  dvd_next;
    logic             q_bit;

    always_comb begin
        start_ok  = div_start && !flush;
        signed_op = !div_op[1];
        a_neg     = signed_op && ALU_A[XLEN-1];
        b_neg     = signed_op && ALU_B[XLEN-1];
        mag_a     = a_neg ? -ALU_A : ALU_A;
        mag_b     = b_neg ? -ALU_B : ALU_B;
        dsr_zero  = (mag_b == '0);
`ifdef MINILA_DIV_EARLY_OUT_EN
        early     = !dsr_zero && (mag_a < mag_b);
`else
        early     = 1'b0;
`endif
        skip_calc = dsr_zero || early;
        last_iter = (cnt == CNT_W'(XLEN - 1));
    end

    div_step #(.W(XLEN)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dsr      (dsr),
        .rem_next (rem_next),
        .dvd_next (dvd_next),
        .q_bit    (q_bit)
    );

    // Flush overrides every transition, including a simultaneous start.
    always_comb begin
        state_next = state;
        div_stall  = 1'b0;
        div_done   = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start_ok) begin
                    div_stall  = 1'b1;
                    state_next = skip_calc ? DIV_FIN : DIV_CALC;
                end
            end
            DIV_CALC: begin
                div_stall = 1'b1;
                if (last_iter) begin
                    state_next = DIV_FIN;
                end
            end
            DIV_FIN: begin
                div_done   = !flush;
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
        if (flush) begin
            state_next = DIV_IDLE;
        end
    end

    // The result is loaded on entry to FIN so it is valid while div_done is high.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state      <= DIV_IDLE;
            cnt        <= '0;
            rem        <= '0;
            dvd        <= '0;
            quo        <= '0;
            dsr        <= '0;
            want_rem   <= 1'b0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            div_result <= '0;
        end else begin
            state <= state_next;
            if (state == DIV_IDLE && start_ok) begin
                want_rem <= div_op[0];
                neg_quo  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                dvd      <= mag_a;
                dsr      <= mag_b;
                rem      <= '0;
                quo      <= '0;
                cnt      <= '0;
                if (skip_calc) begin
                    div_result <= div_pick(div_op[0], dsr_zero ? '1 : '0, mag_a,
                                           (a_neg ^ b_neg) && !dsr_zero, a_neg);
                end
            end else if (state == DIV_CALC && !flush) begin
                rem <= rem_next;
                dvd <= dvd_next;
                quo <= {quo[XLEN-2:0], q_bit};
                cnt <= cnt + CNT_W'(1);
                if (last_iter) begin
                    div_result <= div_pick(want_rem, {quo[XLEN-2:0], q_bit}, rem_next,
                                           neg_quo, neg_rem);
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit: results, latency, stall, flush and reset.
module tb_iter_div_unit;

`ifdef MINILA_DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic        flush;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_result;

    int total = 0;
    int bad   = 0;

    iter_div_unit dut (
        .cpu_clk    (cpu_clk),
        .cpu_rstn   (cpu_rstn),
        .div_start  (div_start),
        .div_op     (div_op),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .flush      (flush),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; presents a start for one cycle (cycle 0).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_op    = op;
        ALU_A     = a;
        ALU_B     = b;
        div_start = 1'b1;
        #1;
        checkOutput("stall_cycle0", {31'd0, div_stall}, 32'd1);
        @(posedge cpu_clk);
        #1;
        div_start = 1'b0;
    endtask

    task automatic runVector(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int          lat;
        int          stalls;
        logic [31:0] got;
        lat    = -1;
        stalls = 0;
        got    = 32'hDEAD_BEEF;
        applyStimulus(op, a, b);
        for (int c = 1; c <= 60; c++) begin
            @(negedge cpu_clk);
            if (div_done) begin
                lat = c;
                got = div_result;
                checkOutput({tag, "_stall_fin"}, {31'd0, div_stall}, 32'd0);
                break;
            end
            if (div_stall) stalls++;
            @(posedge cpu_clk);
            #1;
        end
        checkOutput({tag, "_result"}, got, exp);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_stall_cycles"}, stalls, exp_lat - 1);
        @(posedge cpu_clk);
        #1;
        @(negedge cpu_clk);
        checkOutput({tag, "_done_pulse"}, {31'd0, div_done}, 32'd0);
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        int   done_seen;
        cpu_rstn  = 1'b0;
        div_start = 1'b0;
        div_op    = 2'd0;
        ALU_A     = '0;
        ALU_B     = '0;
        flush     = 1'b0;
        #12;
        checkOutput("reset_stall", {31'd0, div_stall}, 32'd0);
        checkOutput("reset_done", {31'd0, div_done}, 32'd0);
        checkOutput("reset_result", div_result, 32'd0);
        @(posedge cpu_clk);
        #1;
        cpu_rstn = 1'b1;
        @(posedge cpu_clk);
        #1;

        runVector("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14, 33);
        runVector("modu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33);
        runVector("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        runVector("mod_m7_2", 2'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        runVector("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        runVector("mod_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        runVector("div_by0", 2'd0, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
        runVector("mod_by0", 2'd1, 32'd123, 32'd0, 32'd123, 1);
        runVector("mod_neg_by0", 2'd1, 32'hFFFF_FF85, 32'd0, 32'hFFFF_FF85, 1);
        runVector("divu_big", 2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        runVector("modu_big", 2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        runVector("divu_small", 2'd2, 32'd3, 32'd10, 32'd0, EARLY_LAT);
        runVector("mod_small", 2'd1, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EARLY_LAT);

        // Flush at cycle 10 of a divide; the previous result (0xFFFFFFFD) must stay.
        done_seen = 0;
        applyStimulus(2'd2, 32'd1000, 32'd3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge cpu_clk);
            if (div_done) done_seen++;
            @(posedge cpu_clk);
            #1;
        end
        flush = 1'b1;
        @(negedge cpu_clk);
        if (div_done) done_seen++;
        checkOutput("flush_stall_c10", {31'd0, div_stall}, 32'd1);
        @(posedge cpu_clk);
        #1;
        flush = 1'b0;
        @(negedge cpu_clk);
        if (div_done) done_seen++;
        checkOutput("flush_stall_c11", {31'd0, div_stall}, 32'd0);
        checkOutput("flush_no_done", done_seen, 0);
        checkOutput("flush_result_kept", div_result, 32'hFFFF_FFFD);
        @(posedge cpu_clk);
        #1;
        runVector("after_flush", 2'd2, 32'd9, 32'd3, 32'd3, 33);

        // Flush wins over a simultaneous start.
        div_op    = 2'd2;
        ALU_A     = 32'd50;
        ALU_B     = 32'd5;
        div_start = 1'b1;
        flush     = 1'b1;
        #1;
        checkOutput("flush_start_stall", {31'd0, div_stall}, 32'd0);
        @(posedge cpu_clk);
        #1;
        div_start = 1'b0;
        flush     = 1'b0;
        @(negedge cpu_clk);
        checkOutput("flush_start_idle", {31'd0, div_stall}, 32'd0);
        @(posedge cpu_clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        applyStimulus(2'd2, 32'd1000, 32'd3);
        repeat (4) begin
            @(posedge cpu_clk);
            #1;
        end
        cpu_rstn = 1'b0;
        #2;
        checkOutput("midrst_stall", {31'd0, div_stall}, 32'd0);
        checkOutput("midrst_done", {31'd0, div_done}, 32'd0);
        checkOutput("midrst_result", div_result, 32'd0);
        @(posedge cpu_clk);
        #1;
        cpu_rstn  = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge cpu_clk);
            if (div_done || div_stall) done_seen++;
            @(posedge cpu_clk);
            #1;
        end
        checkOutput("midrst_idle", done_seen, 0);
        runVector("after_reset", 2'd0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
